// File: rtl/tow_pkg.sv
// Shared definitions for the tug-of-war game: FSM state encoding, LED lamp
// patterns and small elaboration-time helpers.
package tow_pkg;

    typedef enum logic [2:0] {
        RST    = 3'd0,
        SPLASH = 3'd1,
        DARK   = 3'd2,
        GO     = 3'd3,
        SHOW   = 3'd4,
        DONE   = 3'd5
    } tow_state_e;

    localparam int unsigned LAMP_W = 7;
    localparam logic [LAMP_W-1:0] LAMP_DARK   = 7'b0000000;
    localparam logic [LAMP_W-1:0] LAMP_ALL_ON = 7'b1111111;
    localparam logic [LAMP_W-1:0] LAMP_SPLASH = 7'b1001101;
    localparam logic [LAMP_W-1:0] WIN_LEFT    = 7'b1110000;
    localparam logic [LAMP_W-1:0] WIN_RIGHT   = 7'b0000111;

    localparam int unsigned LFSR_W = 8;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 8'hA5;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tow_lfsr.sv
// 8-bit maximal-length LFSR (x^8+x^6+x^5+x^4+1); exposes its low OUT_W bits
// as the random value. A nonzero seed keeps it off the all-zero lock-up state.
module tow_lfsr
    import tow_pkg::*;
#(
    parameter int unsigned OUT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [OUT_W-1:0] rnd
);

    logic [LFSR_W-1:0] q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= LFSR_SEED;
        end else if (en) begin
            q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
        end
    end

    assign rnd = q[OUT_W-1:0];

endmodule

// File: rtl/tow_referee.sv
// Round sequencer and press arbiter: splash, random dark wait, go lamp,
// press arbitration and result hold, emitting one-cycle point pulses.
module tow_referee
    import tow_pkg::*;
#(
    parameter int unsigned SPLASH_CYC = 16,
    parameter int unsigned DARK_MIN   = 8,
    parameter int unsigned RAND_BITS  = 4,
    parameter int unsigned GO_TIMEOUT = 64,
    parameter int unsigned SHOW_CYC   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pbl,
    input  logic       pbr,
    input  logic       game_over,
    output logic       blank,
    output logic       go_lit,
    output logic       splash,
    output logic       pt_left,
    output logic       pt_right,
    output logic       tie,
    output logic [1:0] jump,
    output logic [2:0] state_o
);

    // Every phase lasts exactly N cycles by loading N-1 and leaving on zero.
    localparam int unsigned MAX_LOAD = max_u(
        max_u(SPLASH_CYC - 32'd1, DARK_MIN + (32'd1 << RAND_BITS) - 32'd2),
        max_u(GO_TIMEOUT - 32'd1, SHOW_CYC - 32'd1));
    localparam int unsigned CNT_W = max_u(32'd1, $clog2(MAX_LOAD + 32'd1));

    localparam logic [CNT_W-1:0] SPLASH_LOAD = CNT_W'(SPLASH_CYC - 32'd1);
    localparam logic [CNT_W-1:0] DARK_BASE   = CNT_W'(DARK_MIN - 32'd1);
    localparam logic [CNT_W-1:0] GO_LOAD     = CNT_W'(GO_TIMEOUT - 32'd1);
    localparam logic [CNT_W-1:0] SHOW_LOAD   = CNT_W'(SHOW_CYC - 32'd1);

    tow_state_e           state, state_nx;
    logic [CNT_W-1:0]     cnt, cnt_nx, dark_load;
    logic [RAND_BITS-1:0] rnd;
    logic                 pbl_q, pbr_q, edge_l, edge_r;
    logic                 pt_left_nx, pt_right_nx, tie_nx;
    logic [1:0]           jump_nx;

    tow_lfsr #(.OUT_W(RAND_BITS)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .rnd (rnd)
    );

    assign edge_l    = pbl & ~pbl_q;
    assign edge_r    = pbr & ~pbr_q;
    assign dark_load = DARK_BASE + CNT_W'(rnd);
    assign state_o   = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RST;
            cnt      <= '0;
            pbl_q    <= 1'b0;
            pbr_q    <= 1'b0;
            blank    <= 1'b1;
            go_lit   <= 1'b0;
            splash   <= 1'b0;
            pt_left  <= 1'b0;
            pt_right <= 1'b0;
            tie      <= 1'b0;
            jump     <= 2'b00;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            pbl_q    <= pbl;
            pbr_q    <= pbr;
            blank    <= (state_nx == RST) || (state_nx == DARK);
            go_lit   <= (state_nx == GO);
            splash   <= (state_nx == SPLASH);
            pt_left  <= pt_left_nx;
            pt_right <= pt_right_nx;
            tie      <= tie_nx;
            jump     <= jump_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        cnt_nx      = (cnt != '0) ? cnt - CNT_W'(1) : cnt;
        pt_left_nx  = 1'b0;
        pt_right_nx = 1'b0;
        tie_nx      = 1'b0;
        jump_nx     = 2'b00;
        case (state)
            RST: begin
                state_nx = SPLASH;
                cnt_nx   = SPLASH_LOAD;
            end
            SPLASH: begin
                if (cnt == '0) begin
                    state_nx = DARK;
                    cnt_nx   = dark_load;
                end
            end
            // A press before the lamp is a false start: the other side scores.
            DARK: begin
                if (edge_l || edge_r) begin
                    state_nx    = SHOW;
                    cnt_nx      = SHOW_LOAD;
                    tie_nx      = edge_l & edge_r;
                    pt_right_nx = edge_l & ~edge_r;
                    pt_left_nx  = edge_r & ~edge_l;
                    jump_nx     = {edge_l, edge_r};
                end else if (cnt == '0) begin
                    state_nx = GO;
                    cnt_nx   = GO_LOAD;
                end
            end
            GO: begin
                if (edge_l || edge_r) begin
                    state_nx    = SHOW;
                    cnt_nx      = SHOW_LOAD;
                    tie_nx      = edge_l & edge_r;
                    pt_left_nx  = edge_l & ~edge_r;
                    pt_right_nx = edge_r & ~edge_l;
                end else if (cnt == '0) begin
                    state_nx = SHOW;
                    cnt_nx   = SHOW_LOAD;
                end
            end
            SHOW: begin
                if (cnt == '0) begin
                    if (game_over) begin
                        state_nx = DONE;
                    end else begin
                        state_nx = DARK;
                        cnt_nx   = dark_load;
                    end
                end
            end
            DONE: state_nx = DONE;
            default: state_nx = RST;
        endcase
    end

endmodule

// File: tb/tb_tow_referee.sv
// Self-checking bench for tow_referee: directed rounds plus random rounds,
// each outcome predicted from the game rules by a small reference model.
module tb_tow_referee;
    import tow_pkg::*;

    localparam int unsigned SPLASH_CYC = 4;
    localparam int unsigned DARK_MIN   = 4;
    localparam int unsigned RAND_BITS  = 2;
    localparam int unsigned GO_TIMEOUT = 8;
    localparam int unsigned SHOW_CYC   = 2;
    localparam int P_DARK = 0;
    localparam int P_GO   = 1;

    logic       clk, rst, pbl, pbr, game_over;
    logic       blank, go_lit, splash, pt_left, pt_right, tie;
    logic [1:0] jump;
    logic [2:0] state_o;
    logic [4:0] pulses;
    logic [2:0] lamps;

    int n_cmp = 0;
    int n_bad = 0;

    assign pulses = {pt_left, pt_right, tie, jump};
    assign lamps  = {blank, go_lit, splash};

    tow_referee #(
        .SPLASH_CYC (SPLASH_CYC),
        .DARK_MIN   (DARK_MIN),
        .RAND_BITS  (RAND_BITS),
        .GO_TIMEOUT (GO_TIMEOUT),
        .SHOW_CYC   (SHOW_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pbl       (pbl),
        .pbr       (pbr),
        .game_over (game_over),
        .blank     (blank),
        .go_lit    (go_lit),
        .splash    (splash),
        .pt_left   (pt_left),
        .pt_right  (pt_right),
        .tie       (tie),
        .jump      (jump),
        .state_o   (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // Rule table: {pt_left, pt_right, tie, jump[1:0]} for presses in a phase.
    function automatic logic [4:0] model(input int phase, input logic l, input logic r);
        if (!l && !r) return 5'b00000;
        if (l && r)   return (phase == P_DARK) ? 5'b00111 : 5'b00100;
        if (phase == P_GO) return l ? 5'b10000 : 5'b01000;
        return l ? 5'b01010 : 5'b10001;
    endfunction

    function automatic logic flag(input int which);
        return (which == P_DARK) ? blank : go_lit;
    endfunction

    task automatic wait_flag(input string tag, input int which);
        int n = 0;
        while (!flag(which) && n < 40) begin
            tick();
            n++;
        end
        chk(tag, 32'(flag(which)), 32'd1);
    endtask

    // Entered just after reset release: splash, dark, then first GO cycle.
    task automatic check_startup();
        int n = 0;
        tick();
        while (splash && n < 40) begin
            n++;
            tick();
        end
        chk("splash_len", 32'(n), 32'(SPLASH_CYC));
        chk("dark_after_splash", 32'(lamps), 32'b100);
        n = 0;
        while (blank && n < 40) begin
            n++;
            tick();
        end
        chk("dark_len_in_range", 32'(n >= int'(DARK_MIN) && n <= int'(DARK_MIN) + 3), 32'd1);
        chk("go_after_dark", 32'(lamps), 32'b010);
    endtask

    // One round; l=r=0 means nobody presses and GO must time out.
    task automatic run_round(input int phase, input logic l, input logic r);
        logic [4:0] want, acc;
        int d, n;
        want = model(phase, l, r);
        if (!l && !r) begin
            wait_flag("wait_go", P_GO);
            n = 0;
            acc = '0;
            while (go_lit && n < 40) begin
                acc |= pulses;
                n++;
                tick();
            end
            chk("go_timeout_len", 32'(n), 32'(GO_TIMEOUT));
            chk("go_timeout_quiet", 32'(acc), 32'd0);
        end else begin
            if (phase == P_DARK) begin
                wait_flag("wait_dark", P_DARK);
                d = int'($urandom_range(0, DARK_MIN - 1));
            end else begin
                wait_flag("wait_go", P_GO);
                d = int'($urandom_range(0, GO_TIMEOUT - 1));
            end
            repeat (d) tick();
            pbl = l;
            pbr = r;
            tick();
        end
        chk(phase == P_DARK ? "dark_result" : "go_result", 32'(pulses), 32'(want));
        chk("result_lamps_off", 32'(lamps), 32'd0);
        chk("result_state_show", 32'(state_o), 32'(SHOW));
        tick();
        chk("pulse_one_cycle", 32'(pulses), 32'd0);
        pbl = 1'b0;
        pbr = 1'b0;
    endtask

    // Button pressed during SHOW and held through the next DARK and GO.
    task automatic held_round();
        logic [4:0] acc = '0;
        int n = 0;
        pbl = 1'b1;
        while (!blank && n < 40) begin
            acc |= pulses;
            n++;
            tick();
        end
        n = 0;
        while (blank && n < 40) begin
            acc |= pulses;
            n++;
            tick();
        end
        chk("held_dark_len", 32'(n >= int'(DARK_MIN) && n <= int'(DARK_MIN) + 3), 32'd1);
        n = 0;
        while (go_lit && n < 40) begin
            acc |= pulses;
            n++;
            tick();
        end
        chk("held_go_len", 32'(n), 32'(GO_TIMEOUT));
        chk("held_no_pulse", 32'(acc | pulses), 32'd0);
        pbl = 1'b0;
    endtask

    initial begin
        logic [4:0] acc;
        rst = 1'b1;
        pbl = 1'b0;
        pbr = 1'b0;
        game_over = 1'b0;
        repeat (2) tick();
        chk("rst_state", 32'(state_o), 32'(RST));
        chk("rst_lamps", 32'(lamps), 32'b100);
        chk("rst_pulses", 32'(pulses), 32'd0);
        rst = 1'b0;
        check_startup();

        run_round(P_GO, 1'b1, 1'b0);
        run_round(P_DARK, 1'b0, 1'b1);
        run_round(P_GO, 1'b1, 1'b1);
        run_round(P_DARK, 1'b1, 1'b1);
        run_round(P_DARK, 1'b1, 1'b0);
        run_round(P_GO, 1'b0, 1'b1);
        run_round(P_GO, 1'b0, 1'b0);
        held_round();

        for (int i = 0; i < 12; i++) begin
            run_round(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)));
        end

        // game_over raised mid-round still lets the round finish.
        wait_flag("wait_go_final", P_GO);
        game_over = 1'b1;
        run_round(P_GO, 1'b0, 1'b1);
        tick();
        chk("done_state", 32'(state_o), 32'(DONE));
        chk("done_lamps", 32'(lamps), 32'd0);
        acc = '0;
        for (int i = 0; i < 6; i++) begin
            pbl = i[0];
            pbr = ~i[0];
            tick();
            acc |= pulses;
        end
        chk("done_ignores_press", 32'(acc), 32'd0);
        chk("done_stays", 32'(state_o), 32'(DONE));

        pbl = 1'b0;
        pbr = 1'b0;
        game_over = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_startup();
        run_round(P_GO, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a dark interval.
        wait_flag("wait_dark_rst", P_DARK);
        tick();
        pbl = 1'b1;
        rst = 1'b1;
        #2;
        chk("async_rst_state", 32'(state_o), 32'(RST));
        chk("async_rst_lamps", 32'(lamps), 32'b100);
        chk("async_rst_pulses", 32'(pulses), 32'd0);
        tick();
        rst = 1'b0;
        pbl = 1'b0;
        check_startup();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
